// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared constants for the iterative DES decryptor: FSM state encoding, the
// FIPS 46-3 permutation tables (IP, FP, E, P, PC1, PC2), the eight S-boxes,
// the decrypt-direction rotation schedule and the permutation helpers.
// All tables use FIPS bit numbering: bit 1 is the MSB of a [1:N] vector.
// -----------------------------------------------------------------------------
package des_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned LAST_ROUND = 16;

    localparam int IP_TBL [0:63] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

    localparam int FP_TBL [0:63] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

    localparam int E_TBL [0:47] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_TBL [0:31] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_TBL [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TBL [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Indexed by {b1, b6, b2..b5} of each 6-bit group, i.e. row*16 + column.
    localparam logic [3:0] SBOX [0:7][0:63] = '{
        '{4'd14,4'd4,4'd13,4'd1,4'd2,4'd15,4'd11,4'd8,4'd3,4'd10,4'd6,4'd12,4'd5,4'd9,4'd0,4'd7,
          4'd0,4'd15,4'd7,4'd4,4'd14,4'd2,4'd13,4'd1,4'd10,4'd6,4'd12,4'd11,4'd9,4'd5,4'd3,4'd8,
          4'd4,4'd1,4'd14,4'd8,4'd13,4'd6,4'd2,4'd11,4'd15,4'd12,4'd9,4'd7,4'd3,4'd10,4'd5,4'd0,
          4'd15,4'd12,4'd8,4'd2,4'd4,4'd9,4'd1,4'd7,4'd5,4'd11,4'd3,4'd14,4'd10,4'd0,4'd6,4'd13},
        '{4'd15,4'd1,4'd8,4'd14,4'd6,4'd11,4'd3,4'd4,4'd9,4'd7,4'd2,4'd13,4'd12,4'd0,4'd5,4'd10,
          4'd3,4'd13,4'd4,4'd7,4'd15,4'd2,4'd8,4'd14,4'd12,4'd0,4'd1,4'd10,4'd6,4'd9,4'd11,4'd5,
          4'd0,4'd14,4'd7,4'd11,4'd10,4'd4,4'd13,4'd1,4'd5,4'd8,4'd12,4'd6,4'd9,4'd3,4'd2,4'd15,
          4'd13,4'd8,4'd10,4'd1,4'd3,4'd15,4'd4,4'd2,4'd11,4'd6,4'd7,4'd12,4'd0,4'd5,4'd14,4'd9},
        '{4'd10,4'd0,4'd9,4'd14,4'd6,4'd3,4'd15,4'd5,4'd1,4'd13,4'd12,4'd7,4'd11,4'd4,4'd2,4'd8,
          4'd13,4'd7,4'd0,4'd9,4'd3,4'd4,4'd6,4'd10,4'd2,4'd8,4'd5,4'd14,4'd12,4'd11,4'd15,4'd1,
          4'd13,4'd6,4'd4,4'd9,4'd8,4'd15,4'd3,4'd0,4'd11,4'd1,4'd2,4'd12,4'd5,4'd10,4'd14,4'd7,
          4'd1,4'd10,4'd13,4'd0,4'd6,4'd9,4'd8,4'd7,4'd4,4'd15,4'd14,4'd3,4'd11,4'd5,4'd2,4'd12},
        '{4'd7,4'd13,4'd14,4'd3,4'd0,4'd6,4'd9,4'd10,4'd1,4'd2,4'd8,4'd5,4'd11,4'd12,4'd4,4'd15,
          4'd13,4'd8,4'd11,4'd5,4'd6,4'd15,4'd0,4'd3,4'd4,4'd7,4'd2,4'd12,4'd1,4'd10,4'd14,4'd9,
          4'd10,4'd6,4'd9,4'd0,4'd12,4'd11,4'd7,4'd13,4'd15,4'd1,4'd3,4'd14,4'd5,4'd2,4'd8,4'd4,
          4'd3,4'd15,4'd0,4'd6,4'd10,4'd1,4'd13,4'd8,4'd9,4'd4,4'd5,4'd11,4'd12,4'd7,4'd2,4'd14},
        '{4'd2,4'd12,4'd4,4'd1,4'd7,4'd10,4'd11,4'd6,4'd8,4'd5,4'd3,4'd15,4'd13,4'd0,4'd14,4'd9,
          4'd14,4'd11,4'd2,4'd12,4'd4,4'd7,4'd13,4'd1,4'd5,4'd0,4'd15,4'd10,4'd3,4'd9,4'd8,4'd6,
          4'd4,4'd2,4'd1,4'd11,4'd10,4'd13,4'd7,4'd8,4'd15,4'd9,4'd12,4'd5,4'd6,4'd3,4'd0,4'd14,
          4'd11,4'd8,4'd12,4'd7,4'd1,4'd14,4'd2,4'd13,4'd6,4'd15,4'd0,4'd9,4'd10,4'd4,4'd5,4'd3},
        '{4'd12,4'd1,4'd10,4'd15,4'd9,4'd2,4'd6,4'd8,4'd0,4'd13,4'd3,4'd4,4'd14,4'd7,4'd5,4'd11,
          4'd10,4'd15,4'd4,4'd2,4'd7,4'd12,4'd9,4'd5,4'd6,4'd1,4'd13,4'd14,4'd0,4'd11,4'd3,4'd8,
          4'd9,4'd14,4'd15,4'd5,4'd2,4'd8,4'd12,4'd3,4'd7,4'd0,4'd4,4'd10,4'd1,4'd13,4'd11,4'd6,
          4'd4,4'd3,4'd2,4'd12,4'd9,4'd5,4'd15,4'd10,4'd11,4'd14,4'd1,4'd7,4'd6,4'd0,4'd8,4'd13},
        '{4'd4,4'd11,4'd2,4'd14,4'd15,4'd0,4'd8,4'd13,4'd3,4'd12,4'd9,4'd7,4'd5,4'd10,4'd6,4'd1,
          4'd13,4'd0,4'd11,4'd7,4'd4,4'd9,4'd1,4'd10,4'd14,4'd3,4'd5,4'd12,4'd2,4'd15,4'd8,4'd6,
          4'd1,4'd4,4'd11,4'd13,4'd12,4'd3,4'd7,4'd14,4'd10,4'd15,4'd6,4'd8,4'd0,4'd5,4'd9,4'd2,
          4'd6,4'd11,4'd13,4'd8,4'd1,4'd4,4'd10,4'd7,4'd9,4'd5,4'd0,4'd15,4'd14,4'd2,4'd3,4'd12},
        '{4'd13,4'd2,4'd8,4'd4,4'd6,4'd15,4'd11,4'd1,4'd10,4'd9,4'd3,4'd14,4'd5,4'd0,4'd12,4'd7,
          4'd1,4'd15,4'd13,4'd8,4'd10,4'd3,4'd7,4'd4,4'd12,4'd5,4'd6,4'd11,4'd0,4'd14,4'd9,4'd2,
          4'd7,4'd11,4'd4,4'd1,4'd9,4'd12,4'd14,4'd2,4'd0,4'd6,4'd10,4'd13,4'd15,4'd3,4'd5,4'd8,
          4'd2,4'd1,4'd14,4'd7,4'd4,4'd10,4'd8,4'd13,4'd15,4'd12,4'd9,4'd0,4'd3,4'd5,4'd6,4'd11}};

    // Right-rotate amount applied before round i (indexed by the round
    // counter). Round 1 uses C0,D0 unrotated; unused slots are zero so the
    // full 5-bit counter can index the table directly.
    localparam logic [1:0] DEC_SHIFT [0:31] = '{
        2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
        2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

    function automatic logic [1:64] ip_perm(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 0; i < 64; i++) y[i+1] = x[IP_TBL[i]];
        return y;
    endfunction

    function automatic logic [1:64] fp_perm(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 0; i < 64; i++) y[i+1] = x[FP_TBL[i]];
        return y;
    endfunction

    function automatic logic [1:48] e_expand(input logic [1:32] x);
        logic [1:48] y;
        for (int i = 0; i < 48; i++) y[i+1] = x[E_TBL[i]];
        return y;
    endfunction

    function automatic logic [1:32] p_perm(input logic [1:32] x);
        logic [1:32] y;
        for (int i = 0; i < 32; i++) y[i+1] = x[P_TBL[i]];
        return y;
    endfunction

    // PC1 never references bits 8,16,...,64, so key parity is dropped here.
    function automatic logic [1:56] pc1_perm(input logic [1:64] x);
        logic [1:56] y;
        for (int i = 0; i < 56; i++) y[i+1] = x[PC1_TBL[i]];
        return y;
    endfunction

    function automatic logic [1:48] pc2_perm(input logic [1:56] x);
        logic [1:48] y;
        for (int i = 0; i < 48; i++) y[i+1] = x[PC2_TBL[i]];
        return y;
    endfunction

    // Circular right rotation of one 28-bit key half (bit 28 wraps to bit 1).
    function automatic logic [1:28] rotr28(input logic [1:28] x, input logic [1:0] n);
        logic [1:28] y;
        case (n)
            2'd1:    y = {x[28], x[1:27]};
            2'd2:    y = {x[27:28], x[1:26]};
            default: y = x;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/des_f_function.sv
// -----------------------------------------------------------------------------
// des_f_function
// Combinational DES round function f(R, K): expand R to 48 bits, mix in the
// subkey, substitute through the eight S-boxes and apply P.
// Ports:
//   r     [1:32] right half entering the round
//   k     [1:48] round subkey
//   f_out [1:32] f(R, K)
// -----------------------------------------------------------------------------
module des_f_function
    import des_pkg::*;
(
    input  logic [1:32] r,
    input  logic [1:48] k,
    output logic [1:32] f_out
);

    logic [1:48] x;
    logic [1:32] s_out;

    always_comb begin
        x     = e_expand(r) ^ k;
        s_out = '0;
        // Row is the outer bit pair {b1,b6}, column the inner bits b2..b5.
        for (int s = 0; s < 8; s++) begin
            s_out[4*s+1 +: 4] = SBOX[s][{x[6*s+1], x[6*s+6], x[6*s+2 +: 4]}];
        end
        f_out = p_perm(s_out);
    end

endmodule

// File: rtl/des_decrypt_iter.sv
// -----------------------------------------------------------------------------
// des_decrypt_iter
// Iterative DES decryptor: one Feistel round per clock, sixteen rounds per
// block, with the decrypt key schedule generated on the fly by rotating the
// C/D halves right. Handshake on both sides is valid/ready.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready ciphertext + key offered / block idle and accepting
//   in      [1:64]    ciphertext (bit 1 = MSB)
//   key_in  [1:64]    key, parity bits 8,16,...,64 ignored
//   out_valid/out_ready plaintext available / consumer takes it
//   De      [1:64]    recovered plaintext
//   key_out [1:64]    key captured with this block (for chaining, e.g. 3DES)
// -----------------------------------------------------------------------------
module des_decrypt_iter
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:64] in,
    input  logic [1:64] key_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:64] De,
    output logic [1:64] key_out
);

    state_t      state;
    logic [4:0]  round_cnt;
    logic [1:32] l_q, r_q;
    logic [1:28] c_q, d_q;

    logic [1:28] c_nxt, d_nxt;
    logic [1:48] subkey;
    logic [1:32] f_val;
    logic [1:32] r_nxt;

    // C/D hold the halves of the previous round; rotate them for this round
    // and derive Ki from the rotated pair.
    always_comb begin
        c_nxt  = rotr28(c_q, DEC_SHIFT[round_cnt]);
        d_nxt  = rotr28(d_q, DEC_SHIFT[round_cnt]);
        subkey = pc2_perm({c_nxt, d_nxt});
        r_nxt  = l_q ^ f_val;
    end

    des_f_function u_f (
        .r     (r_q),
        .k     (subkey),
        .f_out (f_val)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            round_cnt <= '0;
            l_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            De        <= '0;
            key_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        {l_q, r_q} <= ip_perm(in);
                        {c_q, d_q} <= pc1_perm(key_in);
                        key_out    <= key_in;
                        round_cnt  <= 5'd1;
                        state      <= ROUND;
                    end
                end
                ROUND: begin
                    l_q <= r_q;
                    r_q <= r_nxt;
                    c_q <= c_nxt;
                    d_q <= d_nxt;
                    if (round_cnt == 5'(LAST_ROUND)) begin
                        // Final swap: output is FP(R16 || L16).
                        De    <= fp_perm({r_nxt, r_q});
                        state <= DONE;
                    end else begin
                        round_cnt <= round_cnt + 5'd1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_decrypt_iter.sv
module tb_des_decrypt_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [1:64] din = '0;
    logic [1:64] key = '0;
    logic [1:64] de;
    logic [1:64] kout;

    des_decrypt_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .key_in    (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .De        (de),
        .key_out   (kout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pt;
        logic [63:0] key;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   hold_valid = 0;
    bit   b2b = 0;
    bit   b2b_seen = 0;
    bit   ov_prev = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after each falling edge; what it sees is
    // exactly what the DUT will sample at the next rising edge.
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                if (b2b) begin
                    if (b2b_seen) check("accept_period", 64'(cyc + 1 - acc_cyc), 64'd18);
                    b2b_seen = 1'b1;
                end
                acc_cyc = cyc + 1;
            end
            if (out_valid) begin
                if (!ov_prev) check("latency", 64'(cyc - acc_cyc), 64'd16);
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got De=%h with no block pending", de);
                end else begin
                    check("De", de, sb[0].pt);
                    check("key_out", kout, sb[0].key);
                    if (out_ready) void'(sb.pop_front());
                end
            end
            ov_prev = out_valid;
        end
    end

    task automatic send(input logic [63:0] k, input logic [63:0] ct, input logic [63:0] pt);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0, expected 1");
            return;
        end
        key = k;
        din = ct;
        in_valid = 1'b1;
        sb.push_back('{pt: pt, key: k});
        @(negedge clk);
        if (!hold_valid) in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1, C1 = 64'h85E813540F0AB405, P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73, C2 = 64'h0000000000000000, P2 = 64'h8787878787878787;
    localparam logic [63:0] K3 = 64'h0000000000000000, C3 = 64'h8CA64DE9C1B123A7, P3 = 64'h0000000000000000;
    localparam logic [63:0] K4 = 64'h0101010101010101;
    localparam logic [63:0] K5 = 64'hFFFFFFFFFFFFFFFF, C5 = 64'h7359B2163E4EDC58, P5 = 64'hFFFFFFFFFFFFFFFF;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_De", de, 64'd0);
        check("rst_key_out", kout, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Known-answer vectors, one at a time
        out_ready = 1'b1;
        send(K1, C1, P1); drain();
        send(K2, C2, P2); drain();
        send(K3, C3, P3); drain();
        send(K4, C3, P3); drain();
        send(K5, C5, P5); drain();

        // Output hold with in_valid noise during ROUND and DONE
        out_ready = 1'b0;
        send(K2, C2, P2);
        repeat (4) @(negedge clk);
        din = C1; key = K1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int t = 0; t < 40 && !out_valid; t++) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 3);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check("hold_out_valid", 64'(out_valid), 64'd1);
        check("hold_De", de, P2);
        @(negedge clk);
        out_ready = 1'b1;
        drain();
        repeat (3) @(negedge clk);
        #1;
        check("post_hold_out_valid", 64'(out_valid), 64'd0);
        check("post_hold_in_ready", 64'(in_ready), 64'd1);

        // Reset in the middle of the rounds
        send(K1, C1, P1);
        repeat (7) @(negedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_De", de, 64'd0);
        check("midrst_key_out", kout, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("after_rst_out_valid", 64'(out_valid), 64'd0);
        check("after_rst_De", de, 64'd0);
        send(K1, C1, P1); drain();

        // Back-to-back blocks
        hold_valid = 1'b1;
        b2b = 1'b1;
        b2b_seen = 1'b0;
        send(K1, C1, P1);
        send(K2, C2, P2);
        send(K3, C3, P3);
        send(K4, C3, P3);
        send(K5, C5, P5);
        in_valid = 1'b0;
        hold_valid = 1'b0;
        drain();
        b2b = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
